// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM state type,
// bubble instruction constant, default reset vector and an alignment helper.
package fetch_stage_pkg;

  typedef enum logic [1:0] {
    F_IDLE = 2'd0,  // nothing outstanding
    F_WAIT = 2'd1,  // one live request outstanding for PCF
    F_DROP = 2'd2   // one stale (wrong-path) request outstanding
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR         = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_RESET_VEC = 32'h0000_0000;

  // Redirect targets are always fetched word-aligned.
  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_stage_pipe_reg_fd.sv
// Fetch->Decode pipeline register with stall, flush and synchronous reset.
// PC+4 / PC+8 are derived from the registered PC so they stay consistent
// with PCD under stall.
module pipe_reg_fd
  import fetch_stage_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        flush,
  input  logic        ld_valid,
  input  logic [31:0] ld_instr,
  input  logic [31:0] ld_pc,
  input  logic        ld_arm,
  output logic        valid,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic [31:0] pc_plus8,
  output logic        arm
);

  logic        valid_q, valid_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc_q, pc_d;
  logic        arm_q, arm_d;

  // Flush beats stall; an unstalled cycle with nothing to load inserts a bubble.
  always_comb begin
    valid_d = valid_q;
    instr_d = instr_q;
    pc_d    = pc_q;
    arm_d   = arm_q;
    if (flush) begin
      valid_d = 1'b0;
      instr_d = NOP_INSTR;
    end else if (!stall) begin
      valid_d = ld_valid;
      instr_d = ld_valid ? ld_instr : NOP_INSTR;
      if (ld_valid) begin
        pc_d  = ld_pc;
        arm_d = ld_arm;
      end
    end
  end

  // Register update with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      instr_q <= NOP_INSTR;
      pc_q    <= 32'h0000_0000;
      arm_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      instr_q <= instr_d;
      pc_q    <= pc_d;
      arm_q   <= arm_d;
    end
  end

  assign valid    = valid_q;
  assign instr    = instr_q;
  assign pc       = pc_q;
  assign pc_plus4 = pc_q + 32'd4;
  assign pc_plus8 = pc_q + 32'd8;
  assign arm      = arm_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns PCF, keeps at most one imem request in
// flight, discards wrong-path responses after a redirect, parks a response
// in a one-entry buffer while Decode is stalled, and feeds the F->D register.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_VEC = DEFAULT_RESET_VEC
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        armF,
  input  logic        PCSrcW,
  input  logic [31:0] ResultW,
  input  logic        BranchTakenE,
  input  logic [31:0] ALUResultE,
  input  logic        RVPCSrcE,
  input  logic [31:0] PCTargetE,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic [31:0] PCPlus8D,
  output logic        armD,
  output logic        ValidD
);

  fetch_state_t state_q, state_d;
  logic [31:0]  pcf_q, pcf_d;
  logic         bufvalid_q, bufvalid_d;
  logic [31:0]  buf_instr_q, buf_instr_d;
  logic [31:0]  buf_pc_q, buf_pc_d;
  logic         buf_arm_q, buf_arm_d;
  logic         req_arm_q, req_arm_d;

  logic         redirect, live_rsp, drain, buf_ok, slot_ready, req;
  logic [31:0]  target, next_pc;
  logic         ld_valid, ld_arm;
  logic [31:0]  ld_instr, ld_pc;

  // Redirect selection, response classification, issue decision and next PC.
  always_comb begin
    redirect = BranchTakenE | RVPCSrcE | PCSrcW;
    if (RVPCSrcE)          target = word_align(PCTargetE);
    else if (BranchTakenE) target = word_align(ALUResultE);
    else                   target = word_align(ResultW);

    // A response is live only for the request PCF names and only if no
    // redirect makes it wrong-path in the same cycle.
    live_rsp = (state_q == F_WAIT) && imem_rvalid && !redirect;
    drain    = bufvalid_q && !StallD && !FlushD;
    // The buffer must have room for whatever the next request returns; a
    // response parked this cycle blocks issue until Decode takes it.
    buf_ok   = redirect || ((!bufvalid_q || drain) && !(live_rsp && StallD));
    // WAIT and DROP can only issue once their outstanding response returns.
    slot_ready = (state_q == F_IDLE) || imem_rvalid;
    req        = reset_n && (!StallF || redirect) && buf_ok && slot_ready;

    // PCF always tracks the next address to fetch, even when no request
    // goes out this cycle (redirect while waiting, response parked in buffer).
    if (redirect)      next_pc = target;
    else if (live_rsp) next_pc = pcf_q + 32'd4;
    else               next_pc = pcf_q;
  end

  // FSM, PCF, skid buffer and F->D load selection.
  always_comb begin
    state_d = state_q;
    if (req) begin
      state_d = F_WAIT;
    end else begin
      case (state_q)
        F_WAIT: begin
          if (imem_rvalid)   state_d = F_IDLE;
          else if (redirect) state_d = F_DROP;
        end
        F_DROP: begin
          if (imem_rvalid) state_d = F_IDLE;
        end
        default: state_d = F_IDLE;
      endcase
    end

    pcf_d     = next_pc;
    req_arm_d = req ? armF : req_arm_q;

    bufvalid_d  = bufvalid_q;
    buf_instr_d = buf_instr_q;
    buf_pc_d    = buf_pc_q;
    buf_arm_d   = buf_arm_q;
    if (redirect) begin
      bufvalid_d = 1'b0;
    end else if (live_rsp && StallD) begin
      bufvalid_d  = 1'b1;
      buf_instr_d = imem_rdata;
      buf_pc_d    = pcf_q;
      buf_arm_d   = req_arm_q;
    end else if (drain) begin
      bufvalid_d = 1'b0;
    end

    ld_valid = bufvalid_q || live_rsp;
    ld_instr = bufvalid_q ? buf_instr_q : imem_rdata;
    ld_pc    = bufvalid_q ? buf_pc_q    : pcf_q;
    ld_arm   = bufvalid_q ? buf_arm_q   : req_arm_q;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= F_IDLE;
      pcf_q       <= RESET_VEC;
      bufvalid_q  <= 1'b0;
      buf_instr_q <= NOP_INSTR;
      buf_pc_q    <= 32'h0000_0000;
      buf_arm_q   <= 1'b0;
      req_arm_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pcf_q       <= pcf_d;
      bufvalid_q  <= bufvalid_d;
      buf_instr_q <= buf_instr_d;
      buf_pc_q    <= buf_pc_d;
      buf_arm_q   <= buf_arm_d;
      req_arm_q   <= req_arm_d;
    end
  end

  assign imem_req  = req;
  assign imem_addr = reset_n ? next_pc : RESET_VEC;

  pipe_reg_fd u_pipe_reg_fd (
    .clk      (clk),
    .reset_n  (reset_n),
    .stall    (StallD),
    .flush    (FlushD),
    .ld_valid (ld_valid),
    .ld_instr (ld_instr),
    .ld_pc    (ld_pc),
    .ld_arm   (ld_arm),
    .valid    (ValidD),
    .instr    (InstrD),
    .pc       (PCD),
    .pc_plus4 (PCPlus4D),
    .pc_plus8 (PCPlus8D),
    .arm      (armD)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a latency-programmable instruction memory, a
// fetch-stream model (expected request addresses and expected D-stage
// instructions, in order) checked every cycle, and directed scenarios with
// hand-computed cycle-exact expectations.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        StallF = 1'b0, StallD = 1'b0, FlushD = 1'b0, armF = 1'b0;
  logic        PCSrcW = 1'b0, BranchTakenE = 1'b0, RVPCSrcE = 1'b0;
  logic [31:0] ResultW = '0, ALUResultE = '0, PCTargetE = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] InstrD, PCD, PCPlus4D, PCPlus8D;
  logic        armD, ValidD;

  always #5 clk = ~clk;

  fetch_stage #(.RESET_VEC(32'h0000_0100)) dut (
    .clk(clk), .reset_n(reset_n), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .armF(armF), .PCSrcW(PCSrcW), .ResultW(ResultW), .BranchTakenE(BranchTakenE),
    .ALUResultE(ALUResultE), .RVPCSrcE(RVPCSrcE), .PCTargetE(PCTargetE),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rvalid(imem_rvalid),
    .imem_rdata(imem_rdata), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .PCPlus8D(PCPlus8D), .armD(armD), .ValidD(ValidD)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got %h, expected nothing", name, act);
  endtask

  // Instruction word stored at each address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hE5A0_0000;
  endfunction

  // ---------------- instruction memory with fixed latency ----------------
  typedef struct {
    int          due;
    logic [31:0] addr;
  } mreq_t;
  mreq_t mq[$];
  int cyc = 0;
  int lat = 1;

  always @(posedge clk) begin
    #1;
    cyc++;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    if (mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rvalid = 1'b1;
      imem_rdata  = mem_word(mq[0].addr);
      void'(mq.pop_front());
    end
  end

  always @(negedge clk) begin
    if (imem_req === 1'b1) mq.push_back('{due: cyc + lat, addr: imem_addr});
  end

  // ---------------- fetch-stream model ----------------
  logic [31:0] exp_req[$];
  logic [31:0] exp_pc[$];
  logic        exp_arm[$];

  task automatic push_req(input logic [31:0] a);
    exp_req.push_back(a);
  endtask

  task automatic push_d(input logic [31:0] a, input logic arm);
    exp_pc.push_back(a);
    exp_arm.push_back(arm);
  endtask

  task automatic push_seq(input logic [31:0] start, input int n, input logic arm);
    logic [31:0] a;
    a = start;
    for (int i = 0; i < n; i++) begin
      push_req(a);
      push_d(a, arm);
      a = a + 32'd4;
    end
  endtask

  // Per-cycle compare of requests and D-stage contents against the model.
  logic        prev_rst = 1'b0, prev_stall = 1'b0, prev_flush = 1'b0;
  logic        m_valid = 1'b0;
  logic [31:0] m_pc = '0;
  logic        m_arm = 1'b0;

  always @(negedge clk) begin : cmp
    logic [31:0] p;
    logic        ar;
    if (!reset_n) begin
      chk("req_in_reset", {31'd0, imem_req}, 32'd0);
    end else if (imem_req === 1'b1) begin
      if (exp_req.size() == 0) fail_now("req_extra", imem_addr);
      else chk("req_addr", imem_addr, exp_req.pop_front());
    end

    if (!prev_rst) begin
      chk("rst_validd", {31'd0, ValidD}, 32'd0);
      chk("rst_instrd", InstrD, 32'd0);
      chk("rst_pcd", PCD, 32'd0);
      chk("rst_pcplus4d", PCPlus4D, 32'd4);
      chk("rst_pcplus8d", PCPlus8D, 32'd8);
      chk("rst_armd", {31'd0, armD}, 32'd0);
      m_valid = 1'b0;
    end else if (prev_flush) begin
      chk("flush_validd", {31'd0, ValidD}, 32'd0);
      chk("flush_instrd", InstrD, NOP_INSTR);
      m_valid = 1'b0;
    end else if (prev_stall) begin
      chk("stall_validd", {31'd0, ValidD}, {31'd0, m_valid});
      if (m_valid) begin
        chk("stall_pcd", PCD, m_pc);
        chk("stall_instrd", InstrD, mem_word(m_pc));
      end
    end else if (ValidD === 1'b1) begin
      if (exp_pc.size() == 0) begin
        fail_now("d_extra", PCD);
      end else begin
        p  = exp_pc.pop_front();
        ar = exp_arm.pop_front();
        chk("d_pcd", PCD, p);
        chk("d_instrd", InstrD, mem_word(p));
        chk("d_pcplus4d", PCPlus4D, p + 32'd4);
        chk("d_pcplus8d", PCPlus8D, p + 32'd8);
        chk("d_armd", {31'd0, armD}, {31'd0, ar});
        m_valid = 1'b1;
        m_pc    = p;
        m_arm   = ar;
      end
    end else begin
      m_valid = 1'b0;
    end
    prev_rst   = reset_n;
    prev_stall = StallD;
    prev_flush = FlushD;
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic clear_ctl();
    StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0;
    PCSrcW = 1'b0; BranchTakenE = 1'b0; RVPCSrcE = 1'b0;
    ResultW = '0; ALUResultE = '0; PCTargetE = '0;
  endtask

  // Hold reset for nrst cycles; returns at the start of the first cycle with reset_n=1.
  task automatic begin_test(input int nrst, input int l, input logic arm);
    reset_n = 1'b0;
    clear_ctl();
    armF = arm;
    lat  = l;
    exp_req.delete();
    exp_pc.delete();
    exp_arm.delete();
    for (int i = 0; i < nrst; i++) begin
      @(negedge clk);
      chk("reset_noreq", {31'd0, imem_req}, 32'd0);
      chk("reset_novalid", {31'd0, ValidD}, 32'd0);
      tick();
    end
    reset_n = 1'b1;
  endtask

  // Stop fetching, let the outstanding response land, then require that every
  // live request issued has shown up in Decode.
  task automatic drain(input string name);
    clear_ctl();
    StallF = 1'b1;
    run(6);
    chk(name, exp_pc.size(), exp_req.size());
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    // Reset and 1-cycle memory streaming.
    begin_test(3, 1, 1'b0);
    push_seq(32'h100, 16, 1'b0);
    @(negedge clk);
    chk("A_c0_req", {31'd0, imem_req}, 32'd1);
    chk("A_c0_addr", imem_addr, 32'h100);
    tick();
    @(negedge clk);
    chk("A_c1_addr", imem_addr, 32'h104);
    chk("A_c1_validd", {31'd0, ValidD}, 32'd0);
    tick();
    @(negedge clk);
    chk("A_c2_addr", imem_addr, 32'h108);
    chk("A_c2_validd", {31'd0, ValidD}, 32'd1);
    chk("A_c2_pcd", PCD, 32'h100);
    chk("A_c2_pc4", PCPlus4D, 32'h104);
    chk("A_c2_pc8", PCPlus8D, 32'h108);
    tick();
    @(negedge clk);
    chk("A_c3_pcd", PCD, 32'h104);
    tick();
    drain("A_tail");

    // StallD held 3 cycles while the 0x104 response arrives.
    begin_test(2, 1, 1'b0);
    push_seq(32'h100, 16, 1'b0);
    run(2);
    StallD = 1'b1;
    @(negedge clk);
    chk("B_c2_noreq", {31'd0, imem_req}, 32'd0);
    chk("B_c2_pcd", PCD, 32'h100);
    tick();
    @(negedge clk);
    chk("B_c3_noreq", {31'd0, imem_req}, 32'd0);
    tick();
    @(negedge clk);
    chk("B_c4_noreq", {31'd0, imem_req}, 32'd0);
    chk("B_c4_instr", InstrD, 32'hE5A0_0100);
    tick();
    StallD = 1'b0;
    @(negedge clk);
    chk("B_c5_req", {31'd0, imem_req}, 32'd1);
    chk("B_c5_addr", imem_addr, 32'h108);
    tick();
    @(negedge clk);
    chk("B_c6_pcd", PCD, 32'h104);
    chk("B_c6_instr", InstrD, 32'hE5A0_0104);
    tick();
    @(negedge clk);
    chk("B_c7_pcd", PCD, 32'h108);
    tick();
    drain("B_tail");

    // 3-cycle memory, RISC-V redirect while 0x108 is outstanding.
    begin_test(2, 3, 1'b0);
    push_req(32'h100); push_req(32'h104); push_req(32'h108);
    push_d(32'h100, 1'b0); push_d(32'h104, 1'b0);
    push_seq(32'h200, 16, 1'b0);
    run(8);
    RVPCSrcE = 1'b1;
    PCTargetE = 32'h202;
    @(negedge clk);
    chk("C_c8_noreq", {31'd0, imem_req}, 32'd0);
    tick();
    RVPCSrcE = 1'b0;
    PCTargetE = '0;
    @(negedge clk);
    chk("C_c9_state", 32'(dut.state_q), 32'(F_DROP));
    chk("C_c9_req", {31'd0, imem_req}, 32'd1);
    chk("C_c9_addr", imem_addr, 32'h200);
    tick();
    @(negedge clk);
    chk("C_c10_validd", {31'd0, ValidD}, 32'd0);
    tick();
    run(2);
    @(negedge clk);
    chk("C_c13_pcd", PCD, 32'h200);
    chk("C_c13_validd", {31'd0, ValidD}, 32'd1);
    tick();
    drain("C_tail");

    // ARM E-stage branch beats ARM W-stage PC write; ARM ISA tagging.
    begin_test(2, 1, 1'b1);
    push_req(32'h100); push_req(32'h104);
    push_d(32'h100, 1'b1);
    push_seq(32'h300, 16, 1'b1);
    run(2);
    BranchTakenE = 1'b1; ALUResultE = 32'h300;
    PCSrcW = 1'b1; ResultW = 32'h400;
    FlushD = 1'b1;
    @(negedge clk);
    chk("D_c2_req", {31'd0, imem_req}, 32'd1);
    chk("D_c2_addr", imem_addr, 32'h300);
    chk("D_c2_armd", {31'd0, armD}, 32'd1);
    tick();
    clear_ctl();
    @(negedge clk);
    chk("D_c3_validd", {31'd0, ValidD}, 32'd0);
    tick();
    @(negedge clk);
    chk("D_c4_pcd", PCD, 32'h300);
    tick();
    drain("D_tail");

    // RISC-V target priority with alignment, PC wrap, FlushD+StallD together.
    begin_test(2, 1, 1'b0);
    push_req(32'h100); push_req(32'h104); push_req(32'hFFFF_FFFC);
    push_d(32'h100, 1'b0); push_d(32'hFFFF_FFFC, 1'b0);
    push_seq(32'h0, 16, 1'b0);
    run(2);
    RVPCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFFE;
    BranchTakenE = 1'b1; ALUResultE = 32'h500;
    @(negedge clk);
    chk("E_c2_addr", imem_addr, 32'hFFFF_FFFC);
    tick();
    clear_ctl();
    @(negedge clk);
    chk("E_c3_wrap_addr", imem_addr, 32'h0);
    tick();
    FlushD = 1'b1;
    StallD = 1'b1;
    @(negedge clk);
    chk("E_c4_pcd", PCD, 32'hFFFF_FFFC);
    chk("E_c4_pc4", PCPlus4D, 32'h0);
    chk("E_c4_pc8", PCPlus8D, 32'h4);
    chk("E_c4_noreq", {31'd0, imem_req}, 32'd0);
    tick();
    FlushD = 1'b0;
    StallD = 1'b0;
    @(negedge clk);
    chk("E_c5_validd", {31'd0, ValidD}, 32'd0);
    chk("E_c5_instrd", InstrD, 32'h0);
    chk("E_c5_addr", imem_addr, 32'h4);
    tick();
    @(negedge clk);
    chk("E_c6_pcd", PCD, 32'h0);
    chk("E_c6_instr", InstrD, 32'hE5A0_0000);
    tick();
    drain("E_tail");

    // Reset mid-request; the stray response lands in F_IDLE and is ignored.
    begin_test(2, 3, 1'b0);
    push_req(32'h100);
    push_seq(32'h100, 16, 1'b0);
    tick();
    reset_n = 1'b0;
    @(negedge clk);
    chk("F_c1_noreq", {31'd0, imem_req}, 32'd0);
    tick();
    tick();
    reset_n = 1'b1;
    StallF = 1'b1;
    @(negedge clk);
    chk("F_c3_noreq", {31'd0, imem_req}, 32'd0);
    tick();
    StallF = 1'b0;
    @(negedge clk);
    chk("F_c4_validd", {31'd0, ValidD}, 32'd0);
    chk("F_c4_req", {31'd0, imem_req}, 32'd1);
    chk("F_c4_addr", imem_addr, 32'h100);
    tick();
    run(3);
    @(negedge clk);
    chk("F_c8_pcd", PCD, 32'h100);
    chk("F_c8_validd", {31'd0, ValidD}, 32'd1);
    tick();
    drain("F_tail");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the combined ARM/RISC-V pipeline. It owns PCF, issues one-outstanding-request fetches to instruction memory, and drops wrong-path responses after a redirect. It also owns the Fetch→Decode pipeline register. It consumes StallF, StallD and FlushD from the hazard unit, and the three redirect sources (ARM W-stage PC write, ARM E-stage branch, RISC-V E-stage branch/jump). Its D-stage outputs feed the decoder and register file.

## Interface
- RESET_VEC, 32'h0000_0000: first fetch address after reset (bits [1:0] must be 0).
- clk  in  1  clock; all state on rising edge.
- reset_n  in  1  synchronous, active-low reset.
- StallF  in  1  hold PCF; no new request.
- StallD  in  1  hold the F→D register.
- FlushD  in  1  clear the F→D register (ValidD←0).
- armF  in  1  ISA of the instruction being fetched; travels with it to armD.
- PCSrcW  in  1  ARM PC write in W; target ResultW.
- ResultW  in  32  ARM W-stage target.
- BranchTakenE  in  1  ARM branch taken in E; target ALUResultE.
- ALUResultE  in  32  ARM E-stage target.
- RVPCSrcE  in  1  RISC-V branch/jump taken in E; target PCTargetE.
- PCTargetE  in  32  RISC-V E-stage target.
- imem_req  out  1  single-cycle request strobe.
- imem_addr  out  32  request address, valid with imem_req.
- imem_rvalid  in  1  response strobe; ≥1 cycle after its request.
- imem_rdata  in  32  instruction word, valid with imem_rvalid.
- InstrD  out  32  decoded-stage instruction.
- PCD  out  32  address of InstrD.
- PCPlus4D  out  32  PCD+4.
- PCPlus8D  out  32  PCD+8 (ARM R15 read value).
- armD  out  1  ISA of InstrD.
- ValidD  out  1  InstrD is a real instruction; 0 is a bubble.

## Operation
- Redirect = BranchTakenE | RVPCSrcE | PCSrcW. Target priority: RVPCSrcE (PCTargetE), then BranchTakenE (ALUResultE), then PCSrcW (ResultW). Target bits [1:0] are forced to 0.
- FSM, state fetch_state_t:
  - F_IDLE: nothing outstanding.
  - F_WAIT: one live request outstanding for PCF.
  - F_DROP: one stale request outstanding.
- A response in F_WAIT that is not dropped goes to the F→D register if !StallD, else to a 1-entry buffer (bufvalid).
- Issue rule. imem_req=1 when reset_n=1, !StallF (a redirect overrides StallF), bufvalid=0 (or it drains this cycle), and one of the following holds:
  - state is F_IDLE;
  - state is F_WAIT with imem_rvalid accepted this cycle;
  - state is F_DROP with imem_rvalid this cycle.
- imem_addr:
  - redirect target if Redirect;
  - else PCF+4 if a live response is consumed this cycle;
  - else PCF.
- PCF is loaded with imem_addr whenever imem_req=1.
- Redirect handling:
  - Redirect in F_WAIT without rvalid → F_DROP.
  - Redirect coinciding with rvalid → response discarded, target issued that cycle.
  - Redirect discards bufvalid.
- Response transitions:
  - F_DROP + rvalid → response dropped; F_WAIT if a request issues, else F_IDLE.
  - rvalid in F_IDLE is ignored.
- F→D register:
  - if FlushD: ValidD←0, InstrD←0;
  - else if !StallD: load the buffer entry if bufvalid, else the live response, else a bubble (ValidD←0).
  - FlushD overrides StallD.
- Arithmetic: all PC sums are 32-bit modulo 2^32 (0xFFFF_FFFC+4 = 0).

## Timing
- Reset values: PCF=RESET_VEC, state=F_IDLE, bufvalid=0, imem_req=0, imem_addr=RESET_VEC, ValidD=0, InstrD=0, PCD=0, PCPlus4D=4, PCPlus8D=8, armD=0.
- First imem_req occurs in the first cycle with reset_n=1.
- Latency: a response at cycle t appears on the D outputs at t+1 (if !StallD).
- With 1-cycle memory the stage sustains one instruction per cycle.
- Redirect at cycle t → imem_req with the target at t (if nothing is outstanding, or rvalid arrives at t); otherwise when the stale response returns.
- Reset asserted mid-request returns all state to reset values. Post-reset stray rvalid is ignored (F_IDLE).

## Structure
- Shared core package holds:
  - fetch_state_t (F_IDLE, F_WAIT, F_DROP);
  - the NOP/bubble constant (32'h0);
  - the default RESET_VEC.
- One sub-module, pipe_reg_fd: the F→D register with stall/flush/reset, instantiated once.

## Test plan
- Reset with RESET_VEC=0x100: reset_n low 3 cycles → imem_req=0, ValidD=0 throughout; first cycle high → imem_req=1, addr 0x100.
- 1-cycle memory, no hazards → requests 0x100, 0x104, 0x108 on consecutive cycles; ValidD=1 each cycle from t+2; PCPlus4D=PCD+4, PCPlus8D=PCD+8.
- StallD held 3 cycles while response for 0x104 arrives:
  - InstrD is frozen and no new request is issued;
  - after release, 0x104 appears next cycle with no loss or duplication.
- 3-cycle memory, RVPCSrcE with PCTargetE=0x202 while 0x108 is outstanding → state F_DROP; the 0x108 response is dropped; next request 0x200 issues on the stale-response cycle.
- BranchTakenE (ALUResultE=0x300) and PCSrcW (ResultW=0x400) in the same cycle → next imem_addr=0x300.
- FlushD and StallD together with a valid instruction in D → ValidD=0 next cycle. Wrap case: PCF=0xFFFF_FFFC → following request 0x0.
